// File: rtl/x2050_panel_pkg.sv
// x2050_panel_pkg
// Shared definitions for the 2050 operator-panel input conditioner:
//   - button index constants, listed in firing priority (index 0 wins)
//   - reset-class / operator-class button masks
//   - button FSM state enum
//   - storage-select and rate switch codes
//   - winner selection helper (isolates the highest-priority pressed button)
package x2050_panel_pkg;

  localparam int NUM_BTN = 8;
  localparam int NUM_RAW = 12;

  // Lower index = higher priority.
  localparam int BTN_POWER_ON     = 0;
  localparam int BTN_SYSTEM_RESET = 1;
  localparam int BTN_PSW_RESTART  = 2;
  localparam int BTN_LOAD         = 3;
  localparam int BTN_SET_IC       = 4;
  localparam int BTN_DISPLAY      = 5;
  localparam int BTN_STORE        = 6;
  localparam int BTN_START        = 7;

  localparam logic [NUM_BTN-1:0] RESET_CLASS_MASK = 8'b0000_1111;
  localparam logic [NUM_BTN-1:0] OPER_CLASS_MASK  = 8'b1111_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FIRE = 2'd1,
    ST_PEND = 2'd2,
    ST_LOCK = 2'd3
  } btn_state_e;

  localparam logic [1:0] STORE_MAIN   = 2'b00;
  localparam logic [1:0] STORE_PROT   = 2'b01;
  localparam logic [1:0] STORE_LOCAL  = 2'b10;
  localparam logic [1:0] STORE_BUMP   = 2'b11;

  localparam logic [1:0] RATE_PROCESS = 2'b00;
  localparam logic [1:0] RATE_SINGLE  = 2'b01;
  localparam logic [1:0] RATE_INSN    = 2'b10;

  // Keep only the lowest set bit: that is the highest-priority button.
  function automatic logic [NUM_BTN-1:0] pick_winner(input logic [NUM_BTN-1:0] btn);
    return btn & (~btn + 8'd1);
  endfunction

endpackage

// File: rtl/x2050_debounce.sv
// x2050_debounce
// One raw panel bit: 2-flop synchronizer followed by a stability counter.
// The debounced level only follows the synchronized value once that value
// has differed from the level for DEBOUNCE_CYCLES consecutive cycles and is
// still different on the following cycle.
// Ports:
//   i_clk   - system clock
//   i_reset - asynchronous active-high reset (clears sync, counter, level)
//   i_raw   - raw asynchronous, possibly bouncing input
//   o_level - debounced level
module x2050_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_raw,
  output logic o_level
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;

  always_comb begin
    sync_d  = {sync_q[0], i_raw};
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync_q[1] == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      level_d = sync_q[1];
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign o_level = level_q;

endmodule

// File: rtl/x2050_panel_input.sv
// x2050_panel_input
// Operator-panel input conditioner. Every raw button and switch bit is
// synchronized and debounced; switch levels are passed straight out, button
// levels feed a one-press-at-a-time FSM that emits a single-cycle pulse for
// the highest-priority pressed button. Operator-class presses wait (PEND)
// while CE maintenance controls are busy; a reset-class press pre-empts.
// Ports:
//   i_clk, i_reset           - clock, asynchronous active-high reset
//   i_raw_*                  - raw buttons (1 bit) and switches (2 bits)
//   i_ce_maint_controls      - downstream CE-maintenance busy
//   o_*_pb                   - one-cycle press pulses
//   o_store_sel_sw, o_rate_sw- debounced switch levels
//   o_pending                - operator press waiting on CE maintenance
module x2050_panel_input
  import x2050_panel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_raw_system_reset,
  input  logic       i_raw_power_on,
  input  logic       i_raw_psw_restart,
  input  logic       i_raw_load,
  input  logic       i_raw_set_ic,
  input  logic       i_raw_display,
  input  logic       i_raw_store,
  input  logic       i_raw_start,
  input  logic [1:0] i_raw_store_sel_sw,
  input  logic [1:0] i_raw_rate_sw,
  input  logic       i_ce_maint_controls,
  output logic       o_system_reset_pb,
  output logic       o_power_on_pb,
  output logic       o_psw_restart_pb,
  output logic       o_load_pb,
  output logic       o_set_ic_pb,
  output logic       o_display_pb,
  output logic       o_store_pb,
  output logic       o_start_pb,
  output logic [1:0] o_store_sel_sw,
  output logic [1:0] o_rate_sw,
  output logic       o_pending
);

  logic [NUM_RAW-1:0] raw_vec;
  logic [NUM_RAW-1:0] level_vec;
  logic [NUM_BTN-1:0] btn_lvl;

  // Bits 0..7 are buttons in priority order, then store_sel, then rate.
  assign raw_vec = {i_raw_rate_sw, i_raw_store_sel_sw,
                    i_raw_start, i_raw_store, i_raw_display, i_raw_set_ic,
                    i_raw_load, i_raw_psw_restart, i_raw_system_reset,
                    i_raw_power_on};

  // ---- synchronize + debounce ----
  for (genvar g = 0; g < NUM_RAW; g++) begin : g_db
    x2050_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_raw   (raw_vec[g]),
      .o_level (level_vec[g])
    );
  end

  assign btn_lvl        = level_vec[NUM_BTN-1:0];
  assign o_store_sel_sw = level_vec[9:8];
  assign o_rate_sw      = level_vec[11:10];

  // ---- button FSM ----
  btn_state_e         state_q, state_d;
  logic [NUM_BTN-1:0] winner_q, winner_d;
  logic [NUM_BTN-1:0] pulse_q, pulse_d;
  logic               pending_q, pending_d;
  logic [NUM_BTN-1:0] any_win;
  logic [NUM_BTN-1:0] rst_win;

  always_comb begin
    any_win  = pick_winner(btn_lvl);
    rst_win  = pick_winner(btn_lvl & RESET_CLASS_MASK);
    state_d  = state_q;
    winner_d = winner_q;
    pulse_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (|btn_lvl) begin
          if (((any_win & OPER_CLASS_MASK) != '0) && i_ce_maint_controls) begin
            state_d  = ST_PEND;
            winner_d = any_win;
          end else begin
            state_d = ST_FIRE;
            pulse_d = any_win;
          end
        end
      end
      ST_PEND: begin
        // Reset-class buttons were all low when PEND was entered, so any
        // one high now has risen and takes over the latched press.
        if (rst_win != '0) begin
          state_d  = ST_FIRE;
          pulse_d  = rst_win;
          winner_d = '0;
        end else if ((btn_lvl & winner_q) == '0) begin
          state_d  = ST_LOCK;
          winner_d = '0;
        end else if (!i_ce_maint_controls) begin
          state_d  = ST_FIRE;
          pulse_d  = winner_q;
          winner_d = '0;
        end
      end
      ST_FIRE: begin
        state_d  = ST_LOCK;
        winner_d = '0;
      end
      ST_LOCK: begin
        if (btn_lvl == '0) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        winner_d = '0;
      end
    endcase
    pending_d = (state_d == ST_PEND);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      winner_q  <= '0;
      pulse_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      winner_q  <= winner_d;
      pulse_q   <= pulse_d;
      pending_q <= pending_d;
    end
  end

  assign o_power_on_pb     = pulse_q[BTN_POWER_ON];
  assign o_system_reset_pb = pulse_q[BTN_SYSTEM_RESET];
  assign o_psw_restart_pb  = pulse_q[BTN_PSW_RESTART];
  assign o_load_pb         = pulse_q[BTN_LOAD];
  assign o_set_ic_pb       = pulse_q[BTN_SET_IC];
  assign o_display_pb      = pulse_q[BTN_DISPLAY];
  assign o_store_pb        = pulse_q[BTN_STORE];
  assign o_start_pb        = pulse_q[BTN_START];
  assign o_pending         = pending_q;

endmodule

// File: tb/tb_x2050_panel_input.sv
// tb_x2050_panel_input
// Directed bench for x2050_panel_input with DEBOUNCE_CYCLES=4. Stimulus
// pushes the expected pulse (edge count + one-hot button vector) into a
// queue; a monitor on the falling clock edge pops and compares whenever any
// pulse output is high, and flags pulses that never arrive.
module tb_x2050_panel_input;

  localparam int D = 4;

  // One-hot pulse vector bits: 0 power_on,1 system_reset,2 psw_restart,
  // 3 load,4 set_ic,5 display,6 store,7 start.
  localparam logic [7:0] V_SYSRST = 8'h02;
  localparam logic [7:0] V_LOAD   = 8'h08;
  localparam logic [7:0] V_DISP   = 8'h20;
  localparam logic [7:0] V_STORE  = 8'h40;
  localparam logic [7:0] V_START  = 8'h80;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       raw_system_reset = 0, raw_power_on = 0, raw_psw_restart = 0, raw_load = 0;
  logic       raw_set_ic = 0, raw_display = 0, raw_store = 0, raw_start = 0;
  logic [1:0] raw_store_sel = 2'b00, raw_rate = 2'b00;
  logic       ce_maint = 1'b0;
  logic       system_reset_pb, power_on_pb, psw_restart_pb, load_pb;
  logic       set_ic_pb, display_pb, store_pb, start_pb;
  logic [1:0] store_sel_sw, rate_sw;
  logic       pending;
  logic [7:0] pb;

  x2050_panel_input #(.DEBOUNCE_CYCLES(D)) dut (
    .i_clk               (clk),
    .i_reset             (rst),
    .i_raw_system_reset  (raw_system_reset),
    .i_raw_power_on      (raw_power_on),
    .i_raw_psw_restart   (raw_psw_restart),
    .i_raw_load          (raw_load),
    .i_raw_set_ic        (raw_set_ic),
    .i_raw_display       (raw_display),
    .i_raw_store         (raw_store),
    .i_raw_start         (raw_start),
    .i_raw_store_sel_sw  (raw_store_sel),
    .i_raw_rate_sw       (raw_rate),
    .i_ce_maint_controls (ce_maint),
    .o_system_reset_pb   (system_reset_pb),
    .o_power_on_pb       (power_on_pb),
    .o_psw_restart_pb    (psw_restart_pb),
    .o_load_pb           (load_pb),
    .o_set_ic_pb         (set_ic_pb),
    .o_display_pb        (display_pb),
    .o_store_pb          (store_pb),
    .o_start_pb          (start_pb),
    .o_store_sel_sw      (store_sel_sw),
    .o_rate_sw           (rate_sw),
    .o_pending           (pending)
  );

  assign pb = {start_pb, store_pb, display_pb, set_ic_pb,
               load_pb, psw_restart_pb, system_reset_pb, power_on_pb};

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [7:0] vec;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_pulse(input int at, input logic [7:0] v);
    exp_t e;
    e.at  = at;
    e.vec = v;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at_edge=%0d", name, act, req, cyc);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].at < cyc) begin
      checks++;
      errors++;
      $display("FAIL missed_pulse actual=none required=%02h@%0d at_edge=%0d",
               q[0].vec, q[0].at, cyc);
      void'(q.pop_front());
    end
    if (pb != 8'h00) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse actual=%02h required=none at_edge=%0d", pb, cyc);
      end else begin
        mon_e = q.pop_front();
        if (mon_e.vec !== pb || mon_e.at != cyc) begin
          errors++;
          $display("FAIL pulse actual=%02h@%0d required=%02h@%0d",
                   pb, cyc, mon_e.vec, mon_e.at);
        end
      end
    end
  end

  initial begin
    int n;

    // Reset state
    step(3);
    chk("reset_pb", int'(pb), 0);
    chk("reset_pending", int'(pending), 0);
    chk("reset_store_sel", int'(store_sel_sw), 0);
    chk("reset_rate", int'(rate_sw), 0);
    rst = 1'b0;
    step(2);

    // Clean press, hold, release, re-press
    n = cyc; raw_start = 1'b1; expect_pulse(n + 8, V_START);
    step(20); raw_start = 1'b0; step(12);
    n = cyc; raw_start = 1'b1; expect_pulse(n + 8, V_START);
    step(12); raw_start = 1'b0; step(12);

    // Bounce: 1,0,1,0 then stays 1
    n = cyc;
    raw_display = 1'b1; step(1);
    raw_display = 1'b0; step(1);
    raw_display = 1'b1; step(1);
    raw_display = 1'b0; step(1);
    raw_display = 1'b1; expect_pulse(n + 4 + 8, V_DISP);
    step(15); raw_display = 1'b0; step(12);

    // Simultaneous load + start; release load while start held
    n = cyc; raw_load = 1'b1; raw_start = 1'b1; expect_pulse(n + 8, V_LOAD);
    step(15); raw_load = 1'b0; step(15);
    chk("simul_no_pending", int'(pending), 0);
    raw_start = 1'b0; step(12);

    // PEND then release by ce_maint
    ce_maint = 1'b1;
    n = cyc; raw_store = 1'b1;
    step(10);
    chk("pend_set", int'(pending), 1);
    step(2);
    ce_maint = 1'b0; expect_pulse(cyc + 1, V_STORE);
    step(2);
    chk("pend_clear", int'(pending), 0);
    step(5); raw_store = 1'b0; step(12);

    // PEND pre-empted by system_reset
    ce_maint = 1'b1;
    n = cyc; raw_store = 1'b1;
    step(10);
    chk("preempt_pend_set", int'(pending), 1);
    raw_system_reset = 1'b1; expect_pulse(cyc + 8, V_SYSRST);
    step(5);
    chk("preempt_still_pend", int'(pending), 1);
    step(10);
    chk("preempt_pend_clear", int'(pending), 0);
    raw_store = 1'b0; raw_system_reset = 1'b0; ce_maint = 1'b0;
    step(12);

    // Switches: latency then a short glitch
    raw_store_sel = 2'b10; raw_rate = 2'b01;
    step(6);
    chk("sw_store_before", int'(store_sel_sw), 0);
    chk("sw_rate_before", int'(rate_sw), 0);
    step(1);
    chk("sw_store_after", int'(store_sel_sw), 2);
    chk("sw_rate_after", int'(rate_sw), 1);
    raw_store_sel = 2'b11; step(3);
    raw_store_sel = 2'b10; step(3);
    chk("glitch_store_mid", int'(store_sel_sw), 2);
    step(6);
    chk("glitch_store_end", int'(store_sel_sw), 2);

    // Async reset during LOCK with start held
    n = cyc; raw_start = 1'b1; expect_pulse(n + 8, V_START);
    step(12);
    #2 rst = 1'b1;
    #1;
    chk("async_pb", int'(pb), 0);
    chk("async_pending", int'(pending), 0);
    chk("async_store_sel", int'(store_sel_sw), 0);
    chk("async_rate", int'(rate_sw), 0);
    step(2);
    rst = 1'b0; expect_pulse(cyc + 8, V_START);
    step(12);
    chk("post_reset_store_sel", int'(store_sel_sw), 2);
    raw_start = 1'b0;
    step(12);

    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
